// File: rtl/game_session_fsm.sv
// rtl/game_session_fsm.sv - runner game-session controller: countdown, play, pause, grace, lives and scoring
module game_session_fsm #(
    parameter int SCORE_W         = 12,
    parameter int LIVES           = 3,
    parameter int LIVES_W         = 2,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int GRACE_TICKS     = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               pulse,
    input  logic               died,
    input  logic               jump,
    input  logic               pause_btn,
    output logic               playing,
    output logic               paused,
    output logic               game_over,
    output logic               reset_game,
    output logic               invulnerable,
    output logic [7:0]         countdown,
    output logic [LIVES_W-1:0] lives_left,
    output logic [SCORE_W-1:0] time_alive,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high_score
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAYING   = 3'd2,
        S_GRACE     = 3'd3,
        S_PAUSED    = 3'd4,
        S_GAMEOVER  = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_jump_q;
    logic                 r_pause_q;
    logic [7:0]           r_grace;
    logic                 r_playing;
    logic                 r_paused;
    logic                 r_game_over;
    logic                 r_reset_game;
    logic                 r_invuln;
    logic [7:0]           r_countdown;
    logic [LIVES_W-1:0]   r_lives;
    logic [SCORE_W-1:0]   r_time;
    logic [SCORE_W-1:0]   r_high;
    logic                 r_new_high;

    logic                 w_jump_rise;
    logic                 w_pause_rise;
    logic [SCORE_W-1:0]   w_score_inc;
    logic [SCORE_W-1:0]   w_score_next;

    assign w_jump_rise  = jump & ~r_jump_q;
    assign w_pause_rise = pause_btn & ~r_pause_q;
    assign w_score_inc  = (r_time == {SCORE_W{1'b1}}) ? r_time : r_time + SCORE_W'(1);
    // Score including a pulse landing this cycle; also the final score on the last death
    assign w_score_next = pulse ? w_score_inc : r_time;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // Edge history resets high so a button held through reset is ignored
            r_state      <= S_IDLE;
            r_jump_q     <= 1'b1;
            r_pause_q    <= 1'b1;
            r_grace      <= '0;
            r_playing    <= 1'b0;
            r_paused     <= 1'b0;
            r_game_over  <= 1'b0;
            r_reset_game <= 1'b1;
            r_invuln     <= 1'b0;
            r_countdown  <= '0;
            r_lives      <= LIVES_W'(LIVES);
            r_time       <= '0;
            r_high       <= '0;
            r_new_high   <= 1'b0;
        end else begin
            r_jump_q  <= jump;
            r_pause_q <= pause_btn;
            case (r_state)
                S_IDLE: begin
                    if (w_jump_rise) begin
                        r_reset_game <= 1'b0;
                        r_time       <= '0;
                        r_lives      <= LIVES_W'(LIVES);
                        if (COUNTDOWN_TICKS == 0) begin
                            r_state   <= S_PLAYING;
                            r_playing <= 1'b1;
                        end else begin
                            r_state     <= S_COUNTDOWN;
                            r_countdown <= 8'(COUNTDOWN_TICKS);
                        end
                    end
                end
                S_COUNTDOWN: begin
                    if (pulse) begin
                        r_countdown <= r_countdown - 8'd1;
                        if (r_countdown == 8'd1) begin
                            r_state   <= S_PLAYING;
                            r_playing <= 1'b1;
                        end
                    end
                end
                S_PLAYING: begin
                    r_time <= w_score_next;
                    if (died) begin
                        if (r_lives > LIVES_W'(1)) begin
                            r_lives <= r_lives - LIVES_W'(1);
                            if (GRACE_TICKS != 0) begin
                                r_state  <= S_GRACE;
                                r_invuln <= 1'b1;
                                r_grace  <= 8'(GRACE_TICKS);
                            end
                        end else begin
                            r_lives     <= '0;
                            r_state     <= S_GAMEOVER;
                            r_playing   <= 1'b0;
                            r_game_over <= 1'b1;
                            if (w_score_next > r_high) begin
                                r_high     <= w_score_next;
                                r_new_high <= 1'b1;
                            end else begin
                                r_new_high <= 1'b0;
                            end
                        end
                    end else if (w_pause_rise) begin
                        r_state   <= S_PAUSED;
                        r_playing <= 1'b0;
                        r_paused  <= 1'b1;
                    end
                end
                S_GRACE: begin
                    if (pulse) begin
                        r_time  <= w_score_inc;
                        r_grace <= r_grace - 8'd1;
                        if (r_grace == 8'd1) begin
                            r_state  <= S_PLAYING;
                            r_invuln <= 1'b0;
                        end
                    end
                end
                S_PAUSED: begin
                    if (w_pause_rise) begin
                        r_state   <= S_PLAYING;
                        r_paused  <= 1'b0;
                        r_playing <= 1'b1;
                    end
                end
                S_GAMEOVER: begin
                    if (w_jump_rise) begin
                        r_state      <= S_IDLE;
                        r_game_over  <= 1'b0;
                        r_new_high   <= 1'b0;
                        r_reset_game <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_playing    <= 1'b0;
                    r_paused     <= 1'b0;
                    r_game_over  <= 1'b0;
                    r_reset_game <= 1'b1;
                    r_invuln     <= 1'b0;
                    r_countdown  <= '0;
                    r_new_high   <= 1'b0;
                end
            endcase
        end
    end

    assign playing        = r_playing;
    assign paused         = r_paused;
    assign game_over      = r_game_over;
    assign reset_game     = r_reset_game;
    assign invulnerable   = r_invuln;
    assign countdown      = r_countdown;
    assign lives_left     = r_lives;
    assign time_alive     = r_time;
    assign high_score     = r_high;
    assign new_high_score = r_new_high;

endmodule

// File: tb/tb_game_session_fsm.sv
// tb/tb_game_session_fsm.sv - directed self-checking bench for game_session_fsm
module tb_game_session_fsm;

    logic       clk_in;
    logic       rst_n_in;
    logic       pulse;
    logic       died;
    logic       jump;
    logic       pause_btn;
    logic       playing;
    logic       paused;
    logic       game_over;
    logic       reset_game;
    logic       invulnerable;
    logic [7:0] countdown;
    logic [1:0] lives_left;
    logic [3:0] time_alive;
    logic [3:0] high_score;
    logic       new_high_score;

    int total;
    int bad;

    game_session_fsm #(
        .SCORE_W(4), .LIVES(3), .LIVES_W(2), .COUNTDOWN_TICKS(3), .GRACE_TICKS(2)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .pulse(pulse), .died(died),
        .jump(jump), .pause_btn(pause_btn), .playing(playing), .paused(paused),
        .game_over(game_over), .reset_game(reset_game), .invulnerable(invulnerable),
        .countdown(countdown), .lives_left(lives_left), .time_alive(time_alive),
        .high_score(high_score), .new_high_score(new_high_score)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the active edge
    task automatic step(input logic p, input logic d, input logic j, input logic pb);
        @(negedge clk_in);
        pulse = p; died = d; jump = j; pause_btn = pb;
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_game();
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("start_countdown", countdown, 3);
        check("start_reset_game", reset_game, 0);
        check("start_time", time_alive, 0);
        check("start_lives", lives_left, 3);
        step(1, 0, 1, 0);
        check("cd_2", countdown, 2);
        step(1, 0, 1, 0);
        check("cd_1", countdown, 1);
        check("cd_not_playing", playing, 0);
        step(1, 0, 1, 0);
        check("cd_0", countdown, 0);
        check("cd_playing", playing, 1);
    endtask

    task automatic lose_life_with_grace(input int exp_lives);
        step(0, 1, 1, 0);
        check("die_lives", lives_left, exp_lives);
        check("die_invuln", invulnerable, 1);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        check("grace_end_invuln", invulnerable, 0);
        check("grace_end_playing", playing, 1);
    endtask

    task automatic end_game();
        step(0, 0, 0, 0);
        check("go_hold", game_over, 1);
        step(0, 0, 1, 0);
        check("go_idle_reset", reset_game, 1);
        check("go_idle_gameover", game_over, 0);
        check("go_idle_newhigh", new_high_score, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n_in = 1'b0;
        pulse = 0; died = 0; jump = 1; pause_btn = 0;
        #12;
        check("rst_reset_game", reset_game, 1);
        check("rst_lives", lives_left, 3);
        check("rst_playing", playing, 0);
        check("rst_countdown", countdown, 0);
        check("rst_high", high_score, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Jump held through reset must not start a game
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("held_jump_idle", reset_game, 1);
        check("held_jump_cd", countdown, 0);

        // Game 1: lives, grace, simultaneous pulse and final death
        start_game();
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        check("g1_time5", time_alive, 5);
        step(0, 1, 1, 0);
        check("g1_lives2", lives_left, 2);
        check("g1_invuln", invulnerable, 1);
        step(0, 1, 1, 0);
        check("g1_grace_died_ignored", lives_left, 2);
        step(1, 0, 1, 0);
        check("g1_grace_mid", invulnerable, 1);
        step(1, 0, 1, 0);
        check("g1_time7", time_alive, 7);
        check("g1_back_playing", invulnerable, 0);
        lose_life_with_grace(1);
        check("g1_time9", time_alive, 9);
        step(1, 1, 1, 0);
        check("g1_final_time", time_alive, 10);
        check("g1_final_high", high_score, 10);
        check("g1_final_new", new_high_score, 1);
        check("g1_final_lives", lives_left, 0);
        check("g1_final_go", game_over, 1);
        check("g1_final_playing", playing, 0);
        end_game();
        check("g1_high_kept", high_score, 10);

        // Game 2: saturation, pause, pause+died
        start_game();
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0);
        check("g2_sat", time_alive, 15);
        step(0, 0, 1, 1);
        check("g2_paused", paused, 1);
        check("g2_pause_playing", playing, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
        check("g2_pause_time", time_alive, 15);
        check("g2_pause_lives", lives_left, 3);
        check("g2_pause_still", paused, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        check("g2_resume_playing", playing, 1);
        check("g2_resume_paused", paused, 0);
        check("g2_resume_lives", lives_left, 3);
        step(0, 0, 1, 0);
        step(0, 1, 1, 1);
        check("g2_pd_lives", lives_left, 2);
        check("g2_pd_paused", paused, 0);
        check("g2_pd_invuln", invulnerable, 1);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        lose_life_with_grace(1);
        step(0, 1, 1, 0);
        check("g2_final_time", time_alive, 15);
        check("g2_final_high", high_score, 15);
        check("g2_final_new", new_high_score, 1);
        end_game();

        // Game 3: tie with the record is not a new high score
        start_game();
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0);
        lose_life_with_grace(2);
        lose_life_with_grace(1);
        step(0, 1, 1, 0);
        check("g3_final_time", time_alive, 15);
        check("g3_final_new", new_high_score, 0);
        check("g3_final_high", high_score, 15);
        check("g3_final_go", game_over, 1);
        end_game();

        // Game 4: asynchronous reset mid-grace
        start_game();
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        check("g4_in_grace", invulnerable, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("ar_invuln", invulnerable, 0);
        check("ar_playing", playing, 0);
        check("ar_reset_game", reset_game, 1);
        check("ar_lives", lives_left, 3);
        check("ar_time", time_alive, 0);
        check("ar_high", high_score, 0);
        #10;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step(0, 0, 0, 0);
        check("ar_post_idle", reset_game, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
